// File: rtl/bram_in_arbiter.sv
// bram_in_arbiter: round-robin BRAM write-port arbiter with bounded bursts and auto-incrementing address
module bram_in_arbiter #(
  parameter int NUM_REQ   = 20,
  parameter int SEL_W     = 5,
  parameter int ADDR_W    = 10,
  parameter int MAX_BURST = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic [NUM_REQ*ADDR_W-1:0] BASE_ADDR,
  output logic [SEL_W-1:0]          SEL,
  output logic [NUM_REQ-1:0]        GNT,
  output logic                      BRAM_WE,
  output logic [ADDR_W-1:0]         BRAM_ADDR,
  output logic                      BUSY
);
  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
  localparam logic [SEL_W-1:0] LAST_REQ = SEL_W'(NUM_REQ - 1);

  logic                 state_q, state_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [SEL_W-1:0]     owner_q, owner_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 busy_q, busy_d;
  logic [ADDR_W-1:0]    base [NUM_REQ];
  logic [SEL_W-1:0]     win, idx;
  logic                 found;
  logic                 we;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_base
    assign base[i] = BASE_ADDR[i*ADDR_W +: ADDR_W];
  end

  // Only the owner's own request can produce a write; others are ignored until the grant ends.
  assign we        = (state_q == GRANT) && REQ[owner_q];
  assign BRAM_WE   = we;
  assign SEL       = sel_q;
  assign GNT       = gnt_q;
  assign BRAM_ADDR = addr_q;
  assign BUSY      = busy_q;

  // Round-robin search: first requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = SEL_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && REQ[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Grant from IDLE, then count writes until the owner drops REQ or the burst cap is hit.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    if (state_q == IDLE) begin
      if (EN && found) begin
        state_d = GRANT;
        owner_d = win;
        sel_d   = win;
        gnt_d   = NUM_REQ'(1) << win;
        addr_d  = base[win];
        beat_d  = '0;
        busy_d  = 1'b1;
      end
    end else begin
      if (we) begin
        addr_d = addr_q + 1'b1;
        beat_d = beat_q + 1'b1;
      end
      if (!we || beat_q == LAST_BEAT) begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = (owner_q == LAST_REQ) ? '0 : owner_q + 1'b1;
      end
    end
  end

  // State and registered outputs; reset clears everything immediately, even mid-burst.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      beat_q  <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
    end
  end
endmodule

// File: tb/tb_bram_in_arbiter.sv
// tb_bram_in_arbiter: directed self-checking bench for bram_in_arbiter
module tb_bram_in_arbiter;
  localparam int NUM_REQ = 20;
  localparam int SEL_W   = 5;
  localparam int ADDR_W  = 10;

  logic                      CLK = 1'b0;
  logic                      RST, EN;
  logic [NUM_REQ-1:0]        REQ;
  logic [NUM_REQ*ADDR_W-1:0] BASE_ADDR;
  logic [SEL_W-1:0]          SEL;
  logic [NUM_REQ-1:0]        GNT;
  logic                      BRAM_WE;
  logic [ADDR_W-1:0]         BRAM_ADDR;
  logic                      BUSY;
  int checks = 0;
  int failures = 0;
  int order [5] = '{0, 5, 19, 0, 5};

  bram_in_arbiter dut (
    .CLK(CLK), .RST(RST), .EN(EN), .REQ(REQ), .BASE_ADDR(BASE_ADDR),
    .SEL(SEL), .GNT(GNT), .BRAM_WE(BRAM_WE), .BRAM_ADDR(BRAM_ADDR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sel"},  32'(SEL), 0);
    chk({tag, "_gnt"},  32'(GNT), 0);
    chk({tag, "_we"},   32'(BRAM_WE), 0);
    chk({tag, "_addr"}, 32'(BRAM_ADDR), 0);
    chk({tag, "_busy"}, 32'(BUSY), 0);
  endtask

  initial begin
    RST = 1'b1;
    EN = 1'b0;
    REQ = '1;
    BASE_ADDR = '0;
    BASE_ADDR[0*ADDR_W +: ADDR_W]  = 10'h020;
    BASE_ADDR[2*ADDR_W +: ADDR_W]  = 10'h050;
    BASE_ADDR[3*ADDR_W +: ADDR_W]  = 10'h010;
    BASE_ADDR[7*ADDR_W +: ADDR_W]  = 10'h100;
    BASE_ADDR[9*ADDR_W +: ADDR_W]  = 10'h200;
    BASE_ADDR[15*ADDR_W +: ADDR_W] = 10'h0F0;
    BASE_ADDR[19*ADDR_W +: ADDR_W] = 10'h3FE;
    repeat (2) tick;
    chk_reset("rst");
    RST = 1'b0;
    repeat (3) tick;
    chk("en0_gnt", 32'(GNT), 0);
    chk("en0_busy", 32'(BUSY), 0);
    chk("en0_we", 32'(BRAM_WE), 0);

    REQ = 20'h00008;
    EN = 1'b1;
    #1;
    chk("idle_we", 32'(BRAM_WE), 0);
    tick;
    chk("t2_sel", 32'(SEL), 3);
    chk("t2_gnt", 32'(GNT), 32'h8);
    chk("t2_busy", 32'(BUSY), 1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_addr", 32'(BRAM_ADDR), 32'h10 + i);
      chk("t2_we", 32'(BRAM_WE), 1);
      tick;
    end
    REQ = '0;
    #1;
    chk("t2_nowe", 32'(BRAM_WE), 0);
    chk("t2_busy_hold", 32'(BUSY), 1);
    tick;
    chk("t2_exit_gnt", 32'(GNT), 0);
    chk("t2_exit_busy", 32'(BUSY), 0);
    chk("t2_exit_sel", 32'(SEL), 3);
    chk("t2_exit_addr", 32'(BRAM_ADDR), 32'h14);
    REQ = 20'h00028;
    tick;
    chk("ptr4_gnt", 32'(GNT), 32'h20);
    REQ = '0;
    tick;

    RST = 1'b1;
    REQ = 20'h80021;
    tick;
    RST = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick;
      chk("rr_gnt", 32'(GNT), 32'(1) << order[n]);
      chk("rr_sel", 32'(SEL), 32'(order[n]));
      chk("rr_we", 32'(BRAM_WE), 1);
      tick;
      REQ[order[n]] = 1'b0;
      #1;
      chk("rr_cut", 32'(BRAM_WE), 0);
      tick;
      REQ[order[n]] = 1'b1;
      #1;
      chk("rr_bubble_busy", 32'(BUSY), 0);
      chk("rr_bubble_gnt", 32'(GNT), 0);
    end

    REQ = 20'h00080;
    for (int r = 0; r < 2; r++) begin
      tick;
      chk("cap_gnt", 32'(GNT), 32'h80);
      for (int i = 0; i < 16; i++) begin
        chk("cap_addr", 32'(BRAM_ADDR), 32'h100 + i);
        chk("cap_we", 32'(BRAM_WE), 1);
        tick;
      end
      chk("cap_idle_busy", 32'(BUSY), 0);
      chk("cap_idle_gnt", 32'(GNT), 0);
      chk("cap_idle_addr", 32'(BRAM_ADDR), 32'h110);
    end
    REQ = '0;
    tick;

    REQ = 20'h80000;
    tick;
    chk("wrap_sel", 32'(SEL), 19);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_addr", 32'(BRAM_ADDR), (32'h3FE + i) & 32'h3FF);
      tick;
    end
    REQ = '0;
    tick;
    REQ = 20'h80001;
    tick;
    chk("wrap_ptr_gnt", 32'(GNT), 32'h1);
    chk("wrap_ptr_sel", 32'(SEL), 0);
    chk("wrap_ptr_addr", 32'(BRAM_ADDR), 32'h020);
    REQ = '0;
    tick;

    REQ = 20'h00200;
    tick;
    chk("en_fall_addr0", 32'(BRAM_ADDR), 32'h200);
    EN = 1'b0;
    BASE_ADDR[9*ADDR_W +: ADDR_W] = 10'h3AA;
    REQ = 20'h00210;
    #1;
    chk("en_fall_we", 32'(BRAM_WE), 1);
    tick;
    chk("en_fall_addr1", 32'(BRAM_ADDR), 32'h201);
    chk("en_fall_busy", 32'(BUSY), 1);
    REQ = 20'h00010;
    #1;
    chk("nonowner_we", 32'(BRAM_WE), 0);
    repeat (3) tick;
    chk("en0_idle_busy", 32'(BUSY), 0);
    chk("en0_idle_gnt", 32'(GNT), 0);

    EN = 1'b1;
    REQ = 20'h00004;
    repeat (3) tick;
    chk("mid_addr", 32'(BRAM_ADDR), 32'h052);
    chk("mid_we", 32'(BRAM_WE), 1);
    RST = 1'b1;
    #1;
    chk_reset("mid");
    tick;
    chk("mid_we_held", 32'(BRAM_WE), 0);
    RST = 1'b0;
    REQ = 20'h08004;
    tick;
    chk("post_rst_gnt", 32'(GNT), 32'h4);
    chk("post_rst_addr", 32'(BRAM_ADDR), 32'h050);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bram_in_arbiter.md
Name: bram_in_arbiter

Overview:
- Shares one BRAM write port among NUM_REQ requesters using round-robin arbitration with bounded bursts.
- Drives the 5-bit SEL of the 20:1 BRAM input data mux, so the granted requester's 32-bit word reaches the BRAM data input.
- Generates the BRAM write enable and an auto-incrementing write address from a per-requester base address.
- Sits between the requester blocks and the BRAM/mux pair.

Parameters:
- NUM_REQ, 20, number of requesters; must satisfy NUM_REQ <= 2^SEL_W.
- SEL_W, 5, width of the mux select.
- ADDR_W, 10, BRAM address width.
- MAX_BURST, 16, maximum writes per grant; range 1..2^ADDR_W.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  arbitration enable; when low, no new grants are issued.
- REQ  input  NUM_REQ  per-requester write request; the requester holds it high while it has data.
- BASE_ADDR  input  NUM_REQ*ADDR_W  flattened start address per requester; requester i uses bits [i*ADDR_W +: ADDR_W].
- SEL  output  SEL_W  mux select; registered.
- GNT  output  NUM_REQ  one-hot grant; registered.
- BRAM_WE  output  1  BRAM write enable.
- BRAM_ADDR  output  ADDR_W  BRAM write address; registered.
- BUSY  output  1  high while a grant is active.

Behaviour:
- Reset (asynchronous, any time, including mid-burst): immediately force SEL=0, GNT=0, BRAM_ADDR=0, BUSY=0, BRAM_WE=0. Internal state is cleared: state=IDLE, PTR=0, OWNER=0, BEAT=0.
- FSM states: IDLE, GRANT.
- IDLE, when EN=1 and |REQ=1:
  - Winner = first i with REQ[i]=1, searching PTR, PTR+1, …, wrapping modulo NUM_REQ.
  - Next edge: state=GRANT, OWNER=SEL=winner, GNT=onehot(winner), BRAM_ADDR=BASE_ADDR[winner], BEAT=0, BUSY=1.
- IDLE, when EN=0 or no requests: outputs hold their IDLE values (GNT=0, BUSY=0).
- BRAM_WE is combinational: BRAM_WE = (state==GRANT) & REQ[OWNER].
  - The requester presents data on its mux input during any GNT cycle in which it keeps REQ high; the BRAM captures that word at the same edge.
- GRANT, when REQ[OWNER]=1 (write occurs this cycle):
  - BRAM_ADDR increments by 1, wrapping modulo 2^ADDR_W; BEAT increments by 1.
  - If BEAT==MAX_BURST-1, this write is the last of the burst: exit the grant.
- GRANT, when REQ[OWNER]=0: no write this cycle; exit the grant.
- Exit the grant at the next edge:
  - state=IDLE, GNT=0, BUSY=0.
  - PTR=(OWNER+1) mod NUM_REQ; PTR=NUM_REQ-1 wraps to 0.
  - SEL and BRAM_ADDR hold their last values.
- Exactly one bubble cycle (IDLE) separates consecutive grants. This holds even when the same requester is re-granted.
- EN falling during GRANT does not abort the burst; EN only gates new grants from IDLE.
- BASE_ADDR is sampled only at the grant edge; later changes to it are ignored until the next grant.
- Requests from non-owners during GRANT are ignored and never cause a write.
- SEL is never driven to a value >= NUM_REQ.
- GNT has at most one bit set at any time.

Test Plan:
- Reset and idle: assert RST with REQ=all ones -> SEL=0, GNT=0, BRAM_WE=0, BRAM_ADDR=0, BUSY=0; release RST with EN=0 -> no grant.
- Single short burst: REQ[3]=1 with BASE_ADDR[3]=0x010, EN=1; drop REQ[3] after 4 write cycles -> SEL=3, GNT=0x00008, BRAM_WE high for 4 cycles at addresses 0x010–0x013; then IDLE with PTR=4.
- Round-robin order: REQ[0], REQ[5] and REQ[19] held high continuously, each burst cut to 1 write by pulsing that requester's REQ low after its write, PTR=0 -> grant order 0, 5, 19, 0, 5; each grant separated by one idle cycle.
- Burst cap: REQ[7] held high for 40 cycles, BASE_ADDR[7]=0x100 -> 16 writes at 0x100–0x10F, one idle cycle, re-grant to 7 with a fresh burst at 0x100–0x10F.
- Address and pointer wrap: REQ[19] with BASE_ADDR[19]=0x3FE for a 4-write burst -> addresses 0x3FE, 0x3FF, 0x000, 0x001; then PTR=0, so simultaneous REQ[0] and REQ[19] grant 0 first.
- Reset mid-burst: RST asserted during the third write of a REQ[2] burst -> outputs return to reset values in the same cycle, no further BRAM_WE; after release, arbitration restarts from PTR=0.
